// File: rtl/fundamental_finder.sv
// Fundamental pitch finder: scans one streamed FFT magnitude frame, tracks the
// loudest bin inside [MIN_BIN, MAX_BIN], and publishes it at frame end when it
// clears the loudness threshold. Silent or malformed frames leave the published
// index untouched so the downstream FCW never jumps.
module fundamental_finder #(
    parameter int unsigned FRAME_LEN = 1024,
    parameter int unsigned MAG_W     = 32,
    parameter int unsigned MIN_BIN   = 2,
    parameter int unsigned MAX_BIN   = 511
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [MAG_W-1:0] i_mag_tdata,
    input  logic             i_mag_tvalid,
    input  logic             i_mag_tlast,
    output logic             o_mag_tready,
    input  logic [MAG_W-1:0] i_threshold,
    output logic [15:0]      o_fundamental_index,
    output logic             o_index_valid,
    output logic             o_signal_present,
    output logic             o_frame_error
);

    localparam int unsigned      BIN_W    = $clog2(FRAME_LEN);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FRAME_LEN - 1);
    localparam logic [BIN_W-1:0] LO_BIN   = BIN_W'(MIN_BIN);
    localparam logic [BIN_W-1:0] HI_BIN   = BIN_W'(MAX_BIN);

    typedef enum logic {StScan, StReport} state_e;

    state_e           r_state, w_state_d;
    logic [BIN_W-1:0] r_bin, w_bin_d;
    logic [MAG_W-1:0] r_peak_mag, w_peak_mag_d;
    logic [BIN_W-1:0] r_peak_bin, w_peak_bin_d;
    logic             r_good, w_good_d;
    logic [BIN_W-1:0] r_index, w_index_d;
    logic             r_index_valid, w_index_valid_d;
    logic             r_signal_present, w_signal_present_d;
    logic             r_frame_error, w_frame_error_d;
    logic             r_tready, w_tready_d;

    logic w_xfer;
    logic w_in_window;
    logic w_last_bin;

    assign w_xfer      = i_mag_tvalid && r_tready;
    assign w_in_window = (r_bin >= LO_BIN) && (r_bin <= HI_BIN);
    assign w_last_bin  = (r_bin == LAST_BIN);

    // Next-state logic: peak tracking while scanning, publish decision in the report cycle.
    always_comb begin
        w_state_d          = r_state;
        w_bin_d            = r_bin;
        w_peak_mag_d       = r_peak_mag;
        w_peak_bin_d       = r_peak_bin;
        w_good_d           = r_good;
        w_index_d          = r_index;
        w_index_valid_d    = 1'b0;
        w_signal_present_d = r_signal_present;
        w_frame_error_d    = 1'b0;
        w_tready_d         = r_tready;

        unique case (r_state)
            StScan: begin
                w_tready_d = 1'b1;
                if (w_xfer) begin
                    w_bin_d = r_bin + 1'b1;
                    // Strictly greater keeps the lower bin on ties.
                    if (w_in_window && (i_mag_tdata > r_peak_mag)) begin
                        w_peak_mag_d = i_mag_tdata;
                        w_peak_bin_d = r_bin;
                    end
                    if (i_mag_tlast || w_last_bin) begin
                        w_good_d   = i_mag_tlast && w_last_bin;
                        w_state_d  = StReport;
                        w_tready_d = 1'b0;
                    end
                end
            end
            StReport: begin
                if (r_good) begin
                    if (r_peak_mag >= i_threshold) begin
                        w_index_d          = r_peak_bin;
                        w_signal_present_d = 1'b1;
                        w_index_valid_d    = 1'b1;
                    end else begin
                        w_signal_present_d = 1'b0;
                    end
                end else begin
                    w_frame_error_d = 1'b1;
                end
                w_bin_d      = '0;
                w_peak_mag_d = '0;
                w_peak_bin_d = LO_BIN;
                w_tready_d   = 1'b1;
                w_state_d    = StScan;
            end
            default: begin
                w_state_d = StScan;
            end
        endcase
    end

    // State register; reset release is assumed already synchronised to i_clk upstream.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state          <= StScan;
            r_bin            <= '0;
            r_peak_mag       <= '0;
            r_peak_bin       <= LO_BIN;
            r_good           <= 1'b0;
            r_index          <= '0;
            r_index_valid    <= 1'b0;
            r_signal_present <= 1'b0;
            r_frame_error    <= 1'b0;
            r_tready         <= 1'b0;
        end else begin
            r_state          <= w_state_d;
            r_bin            <= w_bin_d;
            r_peak_mag       <= w_peak_mag_d;
            r_peak_bin       <= w_peak_bin_d;
            r_good           <= w_good_d;
            r_index          <= w_index_d;
            r_index_valid    <= w_index_valid_d;
            r_signal_present <= w_signal_present_d;
            r_frame_error    <= w_frame_error_d;
            r_tready         <= w_tready_d;
        end
    end

    assign o_mag_tready        = r_tready;
    assign o_fundamental_index = 16'(r_index);
    assign o_index_valid       = r_index_valid;
    assign o_signal_present    = r_signal_present;
    assign o_frame_error       = r_frame_error;

endmodule

// File: doc/fundamental_finder.md
Name: fundamental_finder

Overview:
- Upstream pitch-detection stage that feeds the scale-correction LUT stage.
- Consumes a streamed FFT magnitude frame, one bin per beat, and tracks the largest-magnitude bin inside a configurable search window.
- At frame end, if the peak clears a loudness threshold, publishes the bin as a 16-bit fundamental index for the LUT stage, which converts it to an FCW.
- On silent or malformed frames, holds the last good index so the downstream FCW never jumps to garbage.

Parameters:
- FRAME_LEN, 1024: bins per FFT frame; equals the LUT stage depth.
- MAG_W, 32: magnitude sample width, unsigned.
- MIN_BIN, 2: lowest bin searched; excludes DC and near-DC.
- MAX_BIN, 511: highest bin searched; positive-frequency half only.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- mag_tdata  input  MAG_W  unsigned FFT bin magnitude
- mag_tvalid  input  1  magnitude beat valid
- mag_tlast  input  1  marks the final bin of a frame
- mag_tready  output  1  stage can accept a beat
- threshold  input  MAG_W  minimum peak magnitude counted as signal; sampled at frame end
- fundamental_index  output  16  registered peak bin, zero-extended from $clog2(FRAME_LEN)
- index_valid  output  1  one-cycle pulse when fundamental_index updates
- signal_present  output  1  level; 1 when the last completed good frame cleared threshold
- frame_error  output  1  one-cycle pulse on a malformed frame

Behaviour:
- Reset is asynchronous assert and synchronous release to clk. Reset values:
  - fundamental_index=0, index_valid=0, signal_present=0, frame_error=0, mag_tready=0.
  - State=SCAN, bin counter=0, peak_mag=0, peak_bin=MIN_BIN.
- mag_tready goes to 1 on the first clk edge after reset release. A beat transfers when tvalid && tready.
- States:
  - SCAN:
    - mag_tready=1.
    - Each transfer increments the bin counter (bin = counter value before increment).
    - If MIN_BIN <= bin <= MAX_BIN and mag_tdata > peak_mag (strictly greater): load peak_mag=mag_tdata, peak_bin=bin.
    - Ties keep the lower bin.
    - The frame ends on the transfer that has tlast=1 or bin==FRAME_LEN-1, whichever comes first. Then go to REPORT.
  - REPORT (exactly 1 cycle):
    - mag_tready=0.
    - Good frame = tlast and bin==FRAME_LEN-1 both true on the ending beat.
    - Good and peak_mag >= threshold: fundamental_index<=peak_bin, signal_present<=1, index_valid pulses.
    - Good and peak_mag < threshold (including all-zero frame): fundamental_index holds, signal_present<=0, no index_valid.
    - Not good (early tlast, or missing tlast at the final bin): frame_error pulses, fundamental_index and signal_present hold, no index_valid.
    - Always clear the counter to 0, peak_mag to 0, and peak_bin to MIN_BIN, then return to SCAN.
- Latency: index_valid and the new fundamental_index appear 2 clk edges after the ending beat transfers. One edge enters REPORT; one edge registers the outputs.
- Back-pressure: the upstream must tolerate one tready-low cycle per frame. Throughput is FRAME_LEN beats per FRAME_LEN+1 cycles.
- Bubbles (tvalid=0) in SCAN do not advance the counter or change state.
- Comparison is full-width unsigned; no truncation of mag_tdata.
- Reset asserted mid-frame discards the partial frame and returns to the reset values immediately.
- index_valid and frame_error are never both 1 in the same cycle.

Test Plan:
- Reset/idle: hold rst=0, then release with no stimulus -> all outputs 0; mag_tready=1 from the first edge after release.
- Single tone: frame of zeros with bin 37=1000, tlast at bin 1023, threshold=100 -> fundamental_index=37, index_valid one pulse 2 edges after the last beat, signal_present=1.
- Window and tie:
  - bin 1=5000, bin 600=9000, bins 40 and 90 both 700, threshold=10 -> index=40.
  - Frame with only bin 0=9999, threshold=1 -> no update, signal_present=0.
- Silence hold: after the index=37 frame, send a frame with peak 50, threshold=100 -> index stays 37, signal_present=0, no index_valid.
- Malformed frames:
  - tlast at bin 500 -> frame_error pulse, index unchanged, the next beat counts as bin 0.
  - No tlast at bin 1023 -> frame_error.
  - A following good frame with peak at bin 12 -> index=12.
- Back-to-back and reset: two consecutive frames with continuous tvalid and random bubbles -> mag_tready low exactly one cycle per frame, both indices correct. Assert rst at bin 300 -> outputs back to 0, the partial frame discarded.
